// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - kitchen-timer core: BCD MM:SS set, countdown and alarm
//
// Purpose: holds an MM:SS value in BCD, set by increment pulses while idle,
// counts down one second per tick, and raises alarm for ALARM_SECS ticks at 00:00.
//
// Ports:
//   in_clk     in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   tick       in   1 Hz single-cycle pulse
//   btn_start  in   start / resume pulse
//   btn_stop   in   pause pulse
//   btn_clear  in   zero the time, return to idle
//   inc_min    in   minutes +1 (idle only)
//   inc_sec    in   seconds +1 (idle only)
//   min_tens   out  BCD minutes tens
//   min_ones   out  BCD minutes ones
//   sec_tens   out  BCD seconds tens (0..5)
//   sec_ones   out  BCD seconds ones
//   running    out  high while counting
//   alarm      out  high while alarming
//   done       out  single-cycle pulse on alarm entry
module countdown_timer #(
  parameter int ALARM_SECS = 10
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);

  logic [1:0] state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       running_q, running_d;
  logic       alarm_q, alarm_d;
  logic       done_q, done_d;

  // One-second BCD decrement of the current time, used only on a RUN tick.
  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic       dec_is_zero;
  logic       time_is_zero;

  assign time_is_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else if (sec_tens_q != 4'd0) begin
      dec_sec_ones = 4'd9;
      dec_sec_tens = sec_tens_q - 4'd1;
    end else if ((min_tens_q != 4'd0) || (min_ones_q != 4'd0)) begin
      dec_sec_ones = 4'd9;
      dec_sec_tens = 4'd5;
      if (min_ones_q != 4'd0) begin
        dec_min_ones = min_ones_q - 4'd1;
      end else begin
        dec_min_ones = 4'd9;
        dec_min_tens = min_tens_q - 4'd1;
      end
    end
    dec_is_zero = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                  (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);
  end

  always_comb begin
    state_d     = state_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    alarm_cnt_d = alarm_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_clear) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (btn_start) begin
          // A start at 00:00 is swallowed; it still outranks the inc pulses.
          if (!time_is_zero) begin
            state_d = ST_RUN;
          end
        end else if (inc_min) begin
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else if (inc_sec) begin
          // Seconds wrap 59 -> 00 without carrying into minutes.
          if (sec_ones_q == 4'd9) begin
            sec_ones_d = 4'd0;
            sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
          end else begin
            sec_ones_d = sec_ones_q + 4'd1;
          end
        end
      end

      ST_RUN: begin
        if (btn_clear) begin
          state_d    = ST_IDLE;
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (btn_stop) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          min_tens_d = dec_min_tens;
          min_ones_d = dec_min_ones;
          sec_tens_d = dec_sec_tens;
          sec_ones_d = dec_sec_ones;
          if (dec_is_zero) begin
            state_d     = ST_ALARM;
            alarm_cnt_d = 8'd0;
          end
        end
      end

      ST_PAUSE: begin
        if (btn_clear) begin
          state_d    = ST_IDLE;
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end

      ST_ALARM: begin
        if (btn_clear || btn_stop || btn_start) begin
          state_d     = ST_IDLE;
          alarm_cnt_d = 8'd0;
        end else if (tick) begin
          if ((alarm_cnt_q + 8'd1) == ALARM_LIMIT) begin
            state_d     = ST_IDLE;
            alarm_cnt_d = 8'd0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        min_tens_d  = 4'd0;
        min_ones_d  = 4'd0;
        sec_tens_d  = 4'd0;
        sec_ones_d  = 4'd0;
        alarm_cnt_d = 8'd0;
      end
    endcase

    // Status flags are registered from the next state so they line up with the digits.
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
    done_d    = (state_d == ST_ALARM) && (state_q != ST_ALARM);
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      alarm_cnt_q <= 8'd0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      done_q      <= done_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic       inc_min;
  logic       inc_sec;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       alarm;
  logic       done;

  int checks;
  int errors;

  logic [15:0] disp;
  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  countdown_timer #(.ALARM_SECS(3)) dut (
    .in_clk    (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .alarm     (alarm),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; btn_start = 0; btn_stop = 0; btn_clear = 0; inc_min = 0; inc_sec = 0;
  endtask

  task automatic p_tick();   tick = 1;      cyc(); tick = 0;      endtask
  task automatic p_start();  btn_start = 1; cyc(); btn_start = 0; endtask
  task automatic p_clear();  btn_clear = 1; cyc(); btn_clear = 0; endtask
  task automatic p_incmin(); inc_min = 1;   cyc(); inc_min = 0;   endtask
  task automatic p_incsec(); inc_sec = 1;   cyc(); inc_sec = 0;   endtask

  task automatic test_reset();
    p_clear();
    p_incmin();
    for (int i = 0; i < 30; i++) p_incsec();
    p_start();
    checks++;
    if (disp !== 16'h0130 || running !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: disp=%h running=%b, expected 0130 running=1", disp, running);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (disp !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: disp=%h run=%b alarm=%b done=%b, expected 0000 0 0 0",
               disp, running, alarm, done);
    end
    cyc();
    rst_n = 1;
    cyc();
    // Still idle: a tick must not move anything and inc must work.
    p_tick();
    p_incsec();
    checks++;
    if (disp !== 16'h0001 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: disp=%h running=%b, expected 0001 running=0", disp, running);
    end
    p_clear();
  endtask

  task automatic test_inc_wrap();
    for (int i = 0; i < 10; i++) p_incmin();
    checks++;
    if (disp !== 16'h1000) begin
      errors++;
      $display("FAIL inc_min_10: disp=%h, expected 1000", disp);
    end
    for (int i = 10; i < 99; i++) p_incmin();
    checks++;
    if (disp !== 16'h9900) begin
      errors++;
      $display("FAIL inc_min_99: disp=%h, expected 9900", disp);
    end
    p_incmin();
    checks++;
    if (disp !== 16'h0000) begin
      errors++;
      $display("FAIL inc_min_wrap: disp=%h, expected 0000", disp);
    end
    for (int i = 0; i < 59; i++) p_incsec();
    checks++;
    if (disp !== 16'h0059) begin
      errors++;
      $display("FAIL inc_sec_59: disp=%h, expected 0059", disp);
    end
    p_incsec();
    p_incsec();
    checks++;
    if (disp !== 16'h0001) begin
      errors++;
      $display("FAIL inc_sec_wrap: disp=%h, expected 0001", disp);
    end
    p_clear();
  endtask

  task automatic test_countdown();
    p_incmin();
    p_start();
    checks++;
    if (disp !== 16'h0100 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_0100: disp=%h running=%b, expected 0100 running=1", disp, running);
    end
    p_tick();
    checks++;
    if (disp !== 16'h0059) begin
      errors++;
      $display("FAIL tick_borrow: disp=%h, expected 0059", disp);
    end
    for (int i = 0; i < 58; i++) p_tick();
    checks++;
    if (disp !== 16'h0001 || alarm !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL tick_0001: disp=%h alarm=%b done=%b, expected 0001 0 0", disp, alarm, done);
    end
    p_tick();
    checks++;
    if (disp !== 16'h0000 || done !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL alarm_entry: disp=%h done=%b alarm=%b run=%b, expected 0000 1 1 0",
               disp, done, alarm, running);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b alarm=%b, expected done=0 alarm=1", done, alarm);
    end
  endtask

  task automatic test_alarm();
    // Continues in ALARM from test_countdown; ALARM_SECS is 3.
    p_tick();
    p_tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_hold_2: alarm=%b, expected 1", alarm);
    end
    p_tick();
    checks++;
    if (alarm !== 1'b0 || running !== 1'b0 || disp !== 16'h0000) begin
      errors++;
      $display("FAIL alarm_expire: alarm=%b run=%b disp=%h, expected 0 0 0000", alarm, running, disp);
    end
    // Second alarm aborted by clear after one tick.
    p_incsec();
    p_start();
    p_tick();
    p_tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_reenter: alarm=%b, expected 1", alarm);
    end
    p_clear();
    checks++;
    if (alarm !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clear: alarm=%b run=%b, expected 0 0", alarm, running);
    end
    // Third alarm: counter must start fresh, so 2 ticks keep alarm high.
    p_incsec();
    p_start();
    p_tick();
    p_tick();
    p_tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_cnt_cleared: alarm=%b, expected 1", alarm);
    end
    p_tick();
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_expire_2: alarm=%b, expected 0", alarm);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10; i++) p_incsec();
    p_start();
    btn_stop = 1; tick = 1;
    cyc();
    btn_stop = 0; tick = 0;
    checks++;
    if (disp !== 16'h0010 || running !== 1'b0) begin
      errors++;
      $display("FAIL stop_with_tick: disp=%h running=%b, expected 0010 running=0", disp, running);
    end
    p_tick();
    p_tick();
    p_incmin();
    checks++;
    if (disp !== 16'h0010) begin
      errors++;
      $display("FAIL pause_hold: disp=%h, expected 0010", disp);
    end
    p_start();
    checks++;
    if (disp !== 16'h0010 || running !== 1'b1) begin
      errors++;
      $display("FAIL resume: disp=%h running=%b, expected 0010 running=1", disp, running);
    end
    p_tick();
    checks++;
    if (disp !== 16'h0009) begin
      errors++;
      $display("FAIL resume_tick: disp=%h, expected 0009", disp);
    end
    p_clear();
    checks++;
    if (disp !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_clear: disp=%h running=%b, expected 0000 running=0", disp, running);
    end
  endtask

  task automatic test_borrow();
    p_start();
    checks++;
    if (running !== 1'b0 || disp !== 16'h0000) begin
      errors++;
      $display("FAIL start_at_zero: running=%b disp=%h, expected 0 0000", running, disp);
    end
    for (int i = 0; i < 10; i++) p_incmin();
    btn_start = 1; tick = 1;
    cyc();
    btn_start = 0; tick = 0;
    checks++;
    if (disp !== 16'h1000 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_with_tick: disp=%h running=%b, expected 1000 running=1", disp, running);
    end
    p_tick();
    checks++;
    if (disp !== 16'h0959) begin
      errors++;
      $display("FAIL full_borrow: disp=%h, expected 0959", disp);
    end
    p_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 0;
    cyc();
    cyc();
    checks++;
    if (disp !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL por_state: disp=%h run=%b alarm=%b done=%b, expected 0000 0 0 0",
               disp, running, alarm, done);
    end
    rst_n = 1;
    cyc();
    test_reset();
    test_inc_wrap();
    test_countdown();
    test_alarm();
    test_pause();
    test_borrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
